// File: rtl/pipe_core.sv
// pipe_core: five-stage (IF, ID, EX, MEM, WB) in-order pipeline with an 8-entry
// register file, a writable instruction memory and a small data memory.
//
// Build option: define PIPE_CORE_FWD_EN to forward EX operands from EX/MEM and
// MEM/WB, leaving only load-use stalls. Without it, ID stalls on any producer
// still in EX or MEM.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   imem_we       instruction-memory write strobe (works during reset too)
//   imem_addr     instruction-memory write address
//   imem_wdata    instruction word to write
//   pc            current fetch address
//   retire_valid  one-cycle pulse when an instruction completes writeback
//   retire_rd     destination register of the retiring instruction
//   retire_data   value written (store data for STORE)
//   stall         IF/ID held this cycle because of a hazard
//   halted        sticky, set when HALT retires
module pipe_core #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          retire_valid,
    output logic [2:0]                    retire_rd,
    output logic [XLEN-1:0]               retire_data,
    output logic                          stall,
    output logic                          halted
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_ADDI, OP_HALT, OP_NOP
    } op_t;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] rf   [8];

    logic            fetch_off;
    logic            fd_valid;
    logic [31:0]     fd_instr;
    logic            de_valid;
    op_t             de_op;
    logic [2:0]      de_rd;
    logic [XLEN-1:0] de_a, de_b, de_imm;
`ifdef PIPE_CORE_FWD_EN
    logic [2:0]      de_rs1, de_rs2;
`endif
    logic            em_valid;
    op_t             em_op;
    logic [2:0]      em_rd;
    logic [XLEN-1:0] em_result, em_sdata;
    logic            mw_valid, mw_halt;
    logic [2:0]      mw_rd;
    logic [XLEN-1:0] mw_data;

    // ID decode; rd is forced to 0 for non-writers so "rd != 0" means "writes"
    op_t             id_op;
    logic [2:0]      id_rd, id_rs1, id_rs2;
    logic            id_use1, id_use2, id_wr, hazard, halt_id;
    logic [XLEN-1:0] id_imm, id_a, id_b;

    always_comb begin
        id_rs1 = fd_instr[22:20];
        id_rs2 = fd_instr[19:17];
        id_imm = XLEN'($signed(fd_instr[16:0]));
        case (fd_instr[31:26])
            6'd0:    id_op = OP_ADD;
            6'd1:    id_op = OP_SUB;
            6'd2:    id_op = OP_LOAD;
            6'd3:    id_op = OP_STORE;
            6'd4:    id_op = OP_ADDI;
            6'd63:   id_op = OP_HALT;
            default: id_op = OP_NOP;
        endcase
        id_use1 = id_op inside {OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_ADDI};
        id_use2 = id_op inside {OP_ADD, OP_SUB, OP_STORE};
        id_wr   = id_op inside {OP_ADD, OP_SUB, OP_LOAD, OP_ADDI};
        id_rd   = id_wr ? fd_instr[25:23] : 3'd0;

        // register read with write-through from the instruction in WB
        if (id_rs1 == 3'd0)                         id_a = '0;
        else if (mw_valid && mw_rd == id_rs1)       id_a = mw_data;
        else                                        id_a = rf[id_rs1];
        if (id_rs2 == 3'd0)                         id_b = '0;
        else if (mw_valid && mw_rd == id_rs2)       id_b = mw_data;
        else                                        id_b = rf[id_rs2];

`ifdef PIPE_CORE_FWD_EN
        hazard = de_valid && de_op == OP_LOAD && de_rd != 3'd0 &&
                 ((id_use1 && de_rd == id_rs1) || (id_use2 && de_rd == id_rs2));
`else
        hazard = (de_valid && de_rd != 3'd0 &&
                  ((id_use1 && de_rd == id_rs1) || (id_use2 && de_rd == id_rs2))) ||
                 (em_valid && em_rd != 3'd0 &&
                  ((id_use1 && em_rd == id_rs1) || (id_use2 && em_rd == id_rs2)));
`endif
        stall   = fd_valid && hazard;
        halt_id = fd_valid && id_op == OP_HALT;
    end

    logic [XLEN-1:0] ex_a, ex_b, ex_result, mem_data;

    always_comb begin
        ex_a = de_a;
        ex_b = de_b;
`ifdef PIPE_CORE_FWD_EN
        // a LOAD never sits in EX/MEM ahead of a consumer: load-use stall
        if (em_valid && em_rd != 3'd0 && em_rd == de_rs1)      ex_a = em_result;
        else if (mw_valid && mw_rd != 3'd0 && mw_rd == de_rs1) ex_a = mw_data;
        if (em_valid && em_rd != 3'd0 && em_rd == de_rs2)      ex_b = em_result;
        else if (mw_valid && mw_rd != 3'd0 && mw_rd == de_rs2) ex_b = mw_data;
`endif
        case (de_op)
            OP_ADD:                     ex_result = ex_a + ex_b;
            OP_SUB:                     ex_result = ex_a - ex_b;
            OP_LOAD, OP_STORE, OP_ADDI: ex_result = ex_a + de_imm;
            default:                    ex_result = '0;
        endcase

        case (em_op)
            OP_LOAD:          mem_data = dmem[em_result[DAW-1:0]];
            OP_STORE:         mem_data = em_sdata;
            OP_HALT, OP_NOP:  mem_data = '0;
            default:          mem_data = em_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset && em_valid && em_op == OP_STORE) dmem[em_result[DAW-1:0]] <= em_sdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= '0;
            fetch_off    <= 1'b0;
            fd_valid     <= 1'b0;
            fd_instr     <= '0;
            de_valid     <= 1'b0;
            de_op        <= OP_NOP;
            de_rd        <= '0;
            de_a         <= '0;
            de_b         <= '0;
            de_imm       <= '0;
`ifdef PIPE_CORE_FWD_EN
            de_rs1       <= '0;
            de_rs2       <= '0;
`endif
            em_valid     <= 1'b0;
            em_op        <= OP_NOP;
            em_rd        <= '0;
            em_result    <= '0;
            em_sdata     <= '0;
            mw_valid     <= 1'b0;
            mw_halt      <= 1'b0;
            mw_rd        <= '0;
            mw_data      <= '0;
            retire_valid <= 1'b0;
            retire_rd    <= '0;
            retire_data  <= '0;
            halted       <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            // IF: hold on hazard; squash and stop fetching once HALT is decoded
            if (!stall) begin
                if (halt_id || fetch_off) begin
                    fd_valid <= 1'b0;
                end else begin
                    fd_valid <= 1'b1;
                    fd_instr <= imem[pc];
                    pc       <= pc + IAW'(1);
                end
            end
            if (halt_id) fetch_off <= 1'b1;

            // ID -> EX: a hazard sends a bubble forward
            de_valid <= fd_valid && !stall;
            de_op    <= id_op;
            de_rd    <= id_rd;
            de_a     <= id_a;
            de_b     <= id_b;
            de_imm   <= id_imm;
`ifdef PIPE_CORE_FWD_EN
            de_rs1   <= id_rs1;
            de_rs2   <= id_rs2;
`endif

            em_valid  <= de_valid;
            em_op     <= de_op;
            em_rd     <= de_rd;
            em_result <= ex_result;
            em_sdata  <= ex_b;

            mw_valid <= em_valid;
            mw_halt  <= em_op == OP_HALT;
            mw_rd    <= em_rd;
            mw_data  <= mem_data;

            retire_valid <= mw_valid;
            retire_rd    <= mw_valid ? mw_rd : 3'd0;
            retire_data  <= mw_valid ? mw_data : '0;
            if (mw_valid && mw_rd != 3'd0) rf[mw_rd] <= mw_data;
            if (mw_valid && mw_halt)       halted    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_core.sv
// Testbench for pipe_core: directed programs plus randomized programs checked
// against an instruction-level reference model. A second, narrow instance
// (XLEN=16, IMEM_DEPTH=4) covers 16-bit wraparound and pc wrap.
module tb_pipe_core;
    logic        clk = 1'b0;
    logic        reset, imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  pc;
    logic        retire_valid, stall, halted;
    logic [2:0]  retire_rd;
    logic [31:0] retire_data;

    logic        reset4, imem_we4;
    logic [1:0]  imem_addr4;
    logic [31:0] imem_wdata4;
    logic [1:0]  pc4;
    logic        retire_valid4, stall4, halted4;
    logic [2:0]  retire_rd4;
    logic [15:0] retire_data4;

    int n_cmp = 0;
    int n_fail = 0;

    int          obs_rd[$];
    logic [31:0] obs_data[$];
    int          obs_edge[$];
    int          stall_cnt;

    always #5 clk = ~clk;

    pipe_core u_dut (
        .clk(clk), .reset(reset), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .pc(pc), .retire_valid(retire_valid),
        .retire_rd(retire_rd), .retire_data(retire_data), .stall(stall), .halted(halted)
    );

    pipe_core #(.XLEN(16), .IMEM_DEPTH(4), .DMEM_DEPTH(16)) u_dut4 (
        .clk(clk), .reset(reset4), .imem_we(imem_we4), .imem_addr(imem_addr4),
        .imem_wdata(imem_wdata4), .pc(pc4), .retire_valid(retire_valid4),
        .retire_rd(retire_rd4), .retire_data(retire_data4), .stall(stall4), .halted(halted4)
    );

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        logic [31:0] w;
        w = '0;
        w[31:26] = op[5:0];
        w[25:23] = rd[2:0];
        w[22:20] = rs1[2:0];
        w[19:17] = rs2[2:0];
        w[16:0]  = imm[16:0];
        return w;
    endfunction

    localparam int ADD = 0, SUB = 1, LOAD = 2, STORE = 3, ADDI = 4, NOP = 5, HALT = 63;

    // Holds reset high and writes the program; ends on a negedge with reset high.
    task automatic load_main(input logic [31:0] p[$]);
        @(negedge clk);
        reset = 1'b1;
        foreach (p[i]) begin
            imem_we = 1'b1; imem_addr = 4'(i); imem_wdata = p[i];
            @(negedge clk);
        end
        imem_we = 1'b0;
    endtask

    // Called on a negedge: releases reset, records retires until halted.
    task automatic run_main(input int budget);
        bit done;
        obs_rd.delete(); obs_data.delete(); obs_edge.delete();
        stall_cnt = 0;
        done = 0;
        reset = 1'b0;
        for (int e = 1; e <= budget && !done; e++) begin
            @(posedge clk);
            #1;
            if (retire_valid) begin
                obs_rd.push_back(int'(retire_rd));
                obs_data.push_back(retire_data);
                obs_edge.push_back(e);
            end
            if (stall) stall_cnt++;
            if (halted) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL run_timeout: halted=%0b after %0d edges, required 1", halted, budget);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
        n_cmp++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %0b want 0", retire_valid); end
        n_cmp++; if (retire_rd !== 3'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", retire_rd); end
        n_cmp++; if (retire_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", retire_data); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    endtask

    task automatic test_basic();
        int exp_edge, exp_stall;
`ifdef PIPE_CORE_FWD_EN
        exp_edge = 7; exp_stall = 0;
`else
        exp_edge = 9; exp_stall = 2;
`endif
        load_main('{enc(ADDI,1,0,0,5), enc(ADDI,2,0,0,7), enc(ADD,3,1,2,0), enc(HALT,0,0,0,0)});
        run_main(60);
        n_cmp++; if (obs_rd.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", obs_rd.size()); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL basic_halted: got %0b want 1", halted); end
        n_cmp++; if (stall_cnt != exp_stall) begin n_fail++; $display("FAIL basic_stall: got %0d want %0d", stall_cnt, exp_stall); end
        if (obs_rd.size() >= 3) begin
            n_cmp++; if (obs_edge[0] != 5) begin n_fail++; $display("FAIL basic_first_edge: got %0d want 5", obs_edge[0]); end
            n_cmp++; if (obs_rd[2] != 3 || obs_data[2] !== 32'd12) begin
                n_fail++; $display("FAIL basic_add: got rd=%0d data=%0d want rd=3 data=12", obs_rd[2], obs_data[2]);
            end
            n_cmp++; if (obs_edge[2] != exp_edge) begin n_fail++; $display("FAIL basic_add_edge: got %0d want %0d", obs_edge[2], exp_edge); end
        end
    endtask

    task automatic test_load_use();
        int exp_stall;
`ifdef PIPE_CORE_FWD_EN
        exp_stall = 1;
`else
        exp_stall = 4;
`endif
        load_main('{enc(ADDI,1,0,0,9), enc(STORE,0,0,1,3), enc(LOAD,4,0,0,3),
                    enc(ADD,5,4,4,0), enc(HALT,0,0,0,0)});
        run_main(60);
        n_cmp++; if (stall_cnt != exp_stall) begin n_fail++; $display("FAIL lu_stall: got %0d want %0d", stall_cnt, exp_stall); end
        n_cmp++; if (obs_rd.size() != 5) begin n_fail++; $display("FAIL lu_count: got %0d want 5", obs_rd.size()); end
        if (obs_rd.size() >= 4) begin
            n_cmp++; if (obs_rd[1] != 0 || obs_data[1] !== 32'd9) begin
                n_fail++; $display("FAIL lu_store: got rd=%0d data=%0d want rd=0 data=9", obs_rd[1], obs_data[1]);
            end
            n_cmp++; if (obs_rd[2] != 4 || obs_data[2] !== 32'd9) begin
                n_fail++; $display("FAIL lu_load: got rd=%0d data=%0d want rd=4 data=9", obs_rd[2], obs_data[2]);
            end
            n_cmp++; if (obs_rd[3] != 5 || obs_data[3] !== 32'd18) begin
                n_fail++; $display("FAIL lu_add: got rd=%0d data=%0d want rd=5 data=18", obs_rd[3], obs_data[3]);
            end
        end
    endtask

    task automatic test_r0();
        load_main('{enc(ADDI,0,0,0,3), enc(ADD,1,0,0,0), enc(ADDI,2,1,0,4), enc(HALT,0,0,0,0)});
        run_main(60);
        if (obs_rd.size() >= 3) begin
            n_cmp++; if (obs_rd[0] != 0) begin n_fail++; $display("FAIL r0_rd: got %0d want 0", obs_rd[0]); end
            n_cmp++; if (obs_rd[1] != 1 || obs_data[1] !== 32'd0) begin
                n_fail++; $display("FAIL r0_add: got rd=%0d data=%0d want rd=1 data=0", obs_rd[1], obs_data[1]);
            end
            n_cmp++; if (obs_data[2] !== 32'd4) begin n_fail++; $display("FAIL r0_r1val: got %0d want 4", obs_data[2]); end
        end else begin
            n_cmp++; n_fail++; $display("FAIL r0_count: got %0d want 4", obs_rd.size());
        end
    endtask

    task automatic test_reset_mid();
        load_main('{enc(ADDI,1,0,0,11), enc(STORE,0,0,1,7), enc(HALT,0,0,0,0)});
        run_main(60);
        load_main('{enc(LOAD,2,0,0,7), enc(STORE,0,0,0,7), enc(HALT,0,0,0,0)});
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // STORE is in EX now: pulse reset for one cycle, and retarget imem[1]
        reset = 1'b1;
        imem_we = 1'b1; imem_addr = 4'd1; imem_wdata = enc(HALT,0,0,0,0);
        #1;
        n_cmp++; if (pc !== 4'd0 || retire_valid !== 1'b0 || retire_rd !== 3'd0 ||
                     retire_data !== 32'd0 || stall !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: pc=%0d rv=%0b rd=%0d data=%h stall=%0b halted=%0b want all 0",
                     pc, retire_valid, retire_rd, retire_data, stall, halted);
        end
        @(negedge clk);
        imem_we = 1'b0;
        run_main(60);
        if (obs_rd.size() >= 1) begin
            n_cmp++; if (obs_edge[0] != 5) begin n_fail++; $display("FAIL mid_first_edge: got %0d want 5", obs_edge[0]); end
            n_cmp++; if (obs_rd[0] != 2 || obs_data[0] !== 32'd11) begin
                n_fail++; $display("FAIL mid_dmem: got rd=%0d data=%0d want rd=2 data=11", obs_rd[0], obs_data[0]);
            end
        end else begin
            n_cmp++; n_fail++; $display("FAIL mid_count: got 0 want 2");
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            logic [31:0] prog[$];
            logic [31:0] mreg[8];
            logic [31:0] mmem[16];
            int          kq[$];
            int          exp_rd[$];
            logic [31:0] exp_data[$];
            int k, rd, rs1, rs2, addr;
            logic [16:0] im;
            logic [31:0] sx, s;
            for (int r = 0; r < 8; r++) mreg[r] = '0;
            for (int i = 0; i < 15; i++) begin
                k   = int'($urandom_range(0, 4));
                rd  = int'($urandom_range(1, 7));
                rs1 = int'($urandom_range(0, 7));
                rs2 = int'($urandom_range(0, 7));
                im  = 17'($urandom);
                if (k == LOAD && kq.size() == 0) k = ADDI;
                if (k == LOAD) begin
                    addr = kq[$urandom_range(0, kq.size() - 1)];
                    rs1  = 0;
                    im   = 17'(addr);
                end
                sx = {{15{im[16]}}, im};
                case (k)
                    ADD:  begin s = mreg[rs1] + mreg[rs2]; mreg[rd] = s; exp_rd.push_back(rd); exp_data.push_back(s); end
                    SUB:  begin s = mreg[rs1] - mreg[rs2]; mreg[rd] = s; exp_rd.push_back(rd); exp_data.push_back(s); end
                    LOAD: begin s = mmem[addr]; mreg[rd] = s; exp_rd.push_back(rd); exp_data.push_back(s); end
                    STORE: begin
                        s = mreg[rs1] + sx;
                        addr = int'(s[3:0]);
                        mmem[addr] = mreg[rs2];
                        if (!(addr inside {kq})) kq.push_back(addr);
                        exp_rd.push_back(0); exp_data.push_back(mreg[rs2]);
                    end
                    default: begin s = mreg[rs1] + sx; mreg[rd] = s; exp_rd.push_back(rd); exp_data.push_back(s); end
                endcase
                prog.push_back(enc(k, rd, rs1, rs2, int'(im)));
            end
            prog.push_back(enc(HALT,0,0,0,0));
            load_main(prog);
            run_main(100);
            n_cmp++; if (obs_rd.size() != 16) begin
                n_fail++; $display("FAIL rand_count[%0d]: got %0d want 16", t, obs_rd.size());
            end
            for (int i = 0; i < 15 && i < obs_rd.size(); i++) begin
                n_cmp++;
                if (obs_rd[i] != exp_rd[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL rand_retire[%0d][%0d]: got rd=%0d data=%h want rd=%0d data=%h",
                             t, i, obs_rd[i], obs_data[i], exp_rd[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_xlen16();
        logic [31:0] p[4];
        int          got_rd[$];
        logic [15:0] got_data[$];
        bit          done;
        p = '{enc(ADDI,1,0,0,1), enc(SUB,6,0,1,0), enc(ADDI,2,2,0,-1), enc(HALT,0,0,0,0)};
        @(negedge clk);
        reset4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_we4 = 1'b1; imem_addr4 = 2'(i); imem_wdata4 = p[i];
            @(negedge clk);
        end
        imem_we4 = 1'b0;
        reset4 = 1'b0;
        done = 0;
        for (int e = 0; e < 40 && !done; e++) begin
            @(posedge clk); #1;
            if (retire_valid4) begin got_rd.push_back(int'(retire_rd4)); got_data.push_back(retire_data4); end
            if (halted4) done = 1;
        end
        n_cmp++; if (!done || got_rd.size() != 4) begin
            n_fail++; $display("FAIL x16_count: halted=%0b retires=%0d want 1/4", done, got_rd.size());
        end
        if (got_rd.size() >= 3) begin
            n_cmp++; if (got_rd[0] != 1 || got_data[0] !== 16'd1) begin
                n_fail++; $display("FAIL x16_addi: got rd=%0d data=%h want rd=1 data=0001", got_rd[0], got_data[0]);
            end
            n_cmp++; if (got_rd[1] != 6 || got_data[1] !== 16'hFFFF) begin
                n_fail++; $display("FAIL x16_sub: got rd=%0d data=%h want rd=6 data=ffff", got_rd[1], got_data[1]);
            end
            n_cmp++; if (got_rd[2] != 2 || got_data[2] !== 16'hFFFF) begin
                n_fail++; $display("FAIL x16_addi_neg: got rd=%0d data=%h want rd=2 data=ffff", got_rd[2], got_data[2]);
            end
        end
    endtask

    task automatic test_pc_wrap();
        @(negedge clk);
        reset4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_we4 = 1'b1; imem_addr4 = 2'(i); imem_wdata4 = enc(NOP,0,0,0,0);
            @(negedge clk);
        end
        imem_we4 = 1'b0;
        n_cmp++; if (pc4 !== 2'd0) begin n_fail++; $display("FAIL wrap_pc0: got %0d want 0", pc4); end
        reset4 = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            n_cmp++; if (int'(pc4) != e % 4) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", e, pc4, e % 4); end
        end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (halted4 !== 1'b0) begin n_fail++; $display("FAIL wrap_halted: got %0b want 0", halted4); end
    endtask

    initial begin
        reset = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        reset4 = 1'b1; imem_we4 = 1'b0; imem_addr4 = '0; imem_wdata4 = '0;
        test_reset();
        test_basic();
        test_load_use();
        test_r0();
        test_reset_mid();
        test_random();
        test_xlen16();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_core.md
PIPE_CORE -- requirements
Module: pipe_core

Parameters
REQ-001 XLEN, default 32: datapath and register width in bits; legal values 16..64.
REQ-002 IMEM_DEPTH, default 16: instruction memory words; a power of 2.
REQ-003 DMEM_DEPTH, default 16: data memory words; a power of 2.

Interface
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_we  input  1  instruction-memory write strobe; honoured in any state, including while reset is high.
REQ-007 imem_addr  input  $clog2(IMEM_DEPTH)  instruction-memory write address.
REQ-008 imem_wdata  input  32  instruction word to write.
REQ-009 pc  output  $clog2(IMEM_DEPTH)  current fetch address.
REQ-010 retire_valid  output  1  one-cycle pulse: an instruction completed writeback.
REQ-011 retire_rd  output  3  destination register of the retired instruction (0 for STORE).
REQ-012 retire_data  output  XLEN  value written (store data for STORE).
REQ-013 stall  output  1  high in any cycle that IF and ID hold because of a hazard.
REQ-014 halted  output  1  sticky; set when HALT retires.

Function
REQ-015 Instruction word: opcode[31:26], rd[25:23], rs1[22:20], rs2[19:17], imm[16:0]; imm is sign-extended to XLEN.
REQ-016 Opcodes:
- 0 ADD: rd=rs1+rs2
- 1 SUB: rd=rs1-rs2
- 2 LOAD: rd=dmem[rs1+imm]
- 3 STORE: dmem[rs1+imm]=rs2
- 4 ADDI: rd=rs1+imm
- 63 HALT
- any other opcode: NOP, no side effects.
REQ-017 Arithmetic is modulo 2^XLEN; a dmem address is the low $clog2(DMEM_DEPTH) bits of rs1+imm.
REQ-018 Eight registers; R0 reads 0 and writes to it are discarded.
REQ-019 Stages are IF, ID, EX, MEM, WB, with one valid bit per pipeline register; an invalid slot is a bubble with no side effects.
REQ-020 With no stalls, an instruction fetched at edge k writes the regfile and pulses retire_valid on edge k+4.
REQ-021 A register written in WB at an edge is visible to a read in ID in the same cycle (write-through).
REQ-022 pc increments by 1 per unstalled cycle and wraps from IMEM_DEPTH-1 to 0.
REQ-023 Load-use hazard (LOAD in EX whose rd≠0 matches rs1/rs2 of the instruction in ID):
- stall=1 for exactly one cycle
- pc and IF/ID hold
- a bubble enters EX.
REQ-024 STORE is performed at the MEM-stage edge; a LOAD in MEM reads dmem combinationally in that stage.
REQ-025 HALT decoded in ID:
- freezes pc
- the instruction in IF is squashed
- no further fetch.
REQ-026 Instructions ahead of HALT complete normally; halted sets on the edge HALT retires and remains set until reset.
REQ-027 imem_we writes imem_wdata to imem[imem_addr] at the edge; a write to the address being fetched in the same cycle fetches the old word.

Reset
REQ-028 While reset is high:
- pc=0
- all valid bits=0
- retire_valid=0, retire_rd=0, retire_data=0
- stall=0, halted=0
- registers R1..R7=0.
REQ-029 Data memory and instruction memory are not cleared by reset.
REQ-030 Reset asserted mid-operation discards all in-flight instructions with no partial regfile or dmem write; fetch restarts at 0 on the first edge after release.

Configuration
REQ-031 Macro PIPE_CORE_FWD_EN selects hazard handling.
REQ-032 PIPE_CORE_FWD_EN defined:
- EX operands are forwarded from EX/MEM (priority), then MEM/WB
- only load-use stalls.
REQ-033 PIPE_CORE_FWD_EN undefined:
- no forwarding
- ID stalls while any rd≠0 in EX or MEM matches a source register
- instructions in WB are covered by REQ-021.

Verification
REQ-034 Load ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; HALT; release reset -> R3=12, retire_valid pulses 4 times, halted=1.
- with PIPE_CORE_FWD_EN: the ADD retires on edge 7 after release, stall never high
- without: stall is high for 2 cycles.
REQ-035 Load ADDI R1,R0,9; STORE R1 at 3(R0); LOAD R4,3(R0); ADD R5,R4,R4 -> one stall cycle (with forwarding), dmem[3]=9, retire_data of the ADD is 18.
REQ-036 SUB R6,R0,R1 with R1=1, XLEN=16 -> retire_data=16'hFFFF; ADDI R1,R1,-1 with R1=0 -> 16'hFFFF.
REQ-037 IMEM_DEPTH=4, program of four NOPs with no HALT -> pc sequence 0,1,2,3,0,1; halted stays 0.
REQ-038 Assert reset for one cycle while a STORE is in EX -> the targeted dmem word is unchanged, all outputs read their reset values, and the first retire occurs on edge 5 after release.
REQ-039 ADDI R0,R0,3 then ADD R1,R0,R0 -> retire_rd=0 with no regfile write; R1=0.
